// File: rtl/signal_mon_pkg.sv
// Shared encodings for the signal-head conflict monitor: light colors,
// fault codes and the monitor FSM states.
package signal_mon_pkg;

   // Light codes, identical to the controller's encoding.
   localparam logic [1:0] RED     = 2'b00;
   localparam logic [1:0] YELLOW  = 2'b01;
   localparam logic [1:0] GREEN   = 2'b10;
   localparam logic [1:0] ILLEGAL = 2'b11;

   // Fault codes; a lower number has higher priority when several fire together.
   localparam logic [2:0] FC_NONE         = 3'd0;
   localparam logic [2:0] FC_ILLEGAL_CODE = 3'd1;
   localparam logic [2:0] FC_CONFLICT     = 3'd2;
   localparam logic [2:0] FC_SKIP_YELLOW  = 3'd3;
   localparam logic [2:0] FC_BAD_SEQ      = 3'd4;
   localparam logic [2:0] FC_SHORT_YELLOW = 3'd5;
   localparam logic [2:0] FC_NO_CLEARANCE = 3'd6;

   typedef enum logic [1:0] {
      MONITOR = 2'd0,
      FAULT   = 2'd1,
      REARM   = 2'd2
   } state_e;

endpackage

// File: rtl/approach_tracker.sv
// Per-approach history: remembers the last sampled color and how many
// consecutive edges it has been held, and flags illegal or out-of-order
// steps between the remembered color and the one being sampled now.
// Transition flags are raw; the top level qualifies them with prev_valid.
module approach_tracker
   import signal_mon_pkg::*;
#(
   parameter int CNT_W      = 4,
   parameter int MIN_YELLOW = 3
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic [1:0] color_i,
   output logic       is_red_o,
   output logic       illegal_o,
   output logic       skip_yellow_o,
   output logic       bad_seq_o,
   output logic       short_yellow_o,
   output logic       red_to_green_o
);

   localparam logic [CNT_W-1:0] DWELL_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);

   logic [1:0]       prev_color_q, prev_color_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;

   // Next history: dwell restarts at 1 on a color change and saturates otherwise.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      prev_color_d = color_i;
      dwell_d      = dwell_q;
      if (color_i != prev_color_q) begin
         dwell_d = CNT_W'(1);
      end else if (dwell_q != DWELL_MAX) begin
         dwell_d = dwell_q + CNT_W'(1);
      end
   end

   // History registers with synchronous active-low clear.
   always_ff @(posedge clock) begin
      // NOTE: reset is sampled on the clock edge only, so it lives inside the clocked branch.
      if (!clear_n) begin
         // NOTE: state registers use non-blocking assignments so all flops update together.
         prev_color_q <= RED;
         dwell_q      <= '0;
      end else begin
         prev_color_q <= prev_color_d;
         dwell_q      <= dwell_d;
      end
   end

   // Per-approach violation flags, judged against the remembered color.
   always_comb begin
      is_red_o       = (color_i == RED);
      illegal_o      = (color_i == ILLEGAL);
      skip_yellow_o  = (prev_color_q == GREEN)  && (color_i == RED);
      bad_seq_o      = ((prev_color_q == YELLOW) && (color_i == GREEN)) ||
                       ((prev_color_q == RED)    && (color_i == YELLOW));
      short_yellow_o = (prev_color_q == YELLOW) && (color_i == RED) &&
                       (dwell_q < MIN_YELLOW_C);
      red_to_green_o = (prev_color_q == RED)    && (color_i == GREEN);
   end

endmodule

// File: rtl/signal_conflict_monitor.sv
// Independent safety monitor for the two signal heads. Latches the first
// conflict or sequencing violation, forces flashing red, and releases only
// after an operator acknowledge plus an all-red re-arm period.
module signal_conflict_monitor
   import signal_mon_pkg::*;
#(
   parameter int MIN_YELLOW    = 3,
   parameter int MIN_RED_CLEAR = 2,
   parameter int CNT_W         = 4
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic [1:0] hwy,
   input  logic [1:0] cntry,
   input  logic       ack,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [1:0] fault_src,
   output logic       flash,
   output logic [7:0] fault_count
);

   localparam logic [CNT_W-1:0] ALLRED_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] RED_CLEAR_C = CNT_W'(MIN_RED_CLEAR);

   // Per-approach flags (h_ = highway, c_ = country road).
   logic h_red, h_illegal, h_skip, h_bad, h_short, h_r2g;
   logic c_red, c_illegal, c_skip, c_bad, c_short, c_r2g;

   approach_tracker #(.CNT_W(CNT_W), .MIN_YELLOW(MIN_YELLOW)) u_hwy (
      .clock          (clock),
      .clear_n        (clear_n),
      .color_i        (hwy),
      .is_red_o       (h_red),
      .illegal_o      (h_illegal),
      .skip_yellow_o  (h_skip),
      .bad_seq_o      (h_bad),
      .short_yellow_o (h_short),
      .red_to_green_o (h_r2g)
   );

   approach_tracker #(.CNT_W(CNT_W), .MIN_YELLOW(MIN_YELLOW)) u_cntry (
      .clock          (clock),
      .clear_n        (clear_n),
      .color_i        (cntry),
      .is_red_o       (c_red),
      .illegal_o      (c_illegal),
      .skip_yellow_o  (c_skip),
      .bad_seq_o      (c_bad),
      .short_yellow_o (c_short),
      .red_to_green_o (c_r2g)
   );

   state_e           state_q, state_d;
   logic             prev_valid_q, prev_valid_d;
   logic [CNT_W-1:0] allred_q, allred_d;
   logic             fault_q, fault_d;
   logic [2:0]       code_q, code_d;
   logic [1:0]       src_q, src_d;
   logic             flash_q, flash_d;
   logic [7:0]       count_q, count_d;

   // Source masks per fault class; bit0 highway, bit1 country.
   logic [1:0] illegal_src, conflict_src, skip_src, bad_src, short_src, noclr_src;
   logic [2:0] win_code;
   logic [1:0] win_src;

   // Consecutive all-red edges, saturating; cleared by any non-red sample.
   always_comb begin
      allred_d = '0;
      if (h_red && c_red) begin
         allred_d = (allred_q == ALLRED_MAX) ? allred_q : allred_q + CNT_W'(1);
      end
   end

   // Violation sources; transition checks are qualified by prev_valid.
   always_comb begin
      illegal_src  = {c_illegal, h_illegal};
      conflict_src = (!h_red && !c_red) ? 2'b11 : 2'b00;
      skip_src     = prev_valid_q ? {c_skip,  h_skip}  : 2'b00;
      bad_src      = prev_valid_q ? {c_bad,   h_bad}   : 2'b00;
      short_src    = prev_valid_q ? {c_short, h_short} : 2'b00;
      noclr_src    = (prev_valid_q && (allred_q < RED_CLEAR_C)) ? {c_r2g, h_r2g} : 2'b00;
   end

   // Priority encoder: lowest fault code wins, carrying only its own sources.
   always_comb begin
      win_code = FC_NONE;
      win_src  = 2'b00;
      if (|illegal_src) begin
         win_code = FC_ILLEGAL_CODE;
         win_src  = illegal_src;
      end else if (|conflict_src) begin
         win_code = FC_CONFLICT;
         win_src  = conflict_src;
      end else if (|skip_src) begin
         win_code = FC_SKIP_YELLOW;
         win_src  = skip_src;
      end else if (|bad_src) begin
         win_code = FC_BAD_SEQ;
         win_src  = bad_src;
      end else if (|short_src) begin
         win_code = FC_SHORT_YELLOW;
         win_src  = short_src;
      end else if (|noclr_src) begin
         win_code = FC_NO_CLEARANCE;
         win_src  = noclr_src;
      end
   end

   // FSM next state and next registered outputs.
   always_comb begin
      state_d      = state_q;
      prev_valid_d = 1'b1;
      fault_d      = fault_q;
      code_d       = code_q;
      src_d        = src_q;
      flash_d      = flash_q;
      count_d      = count_q;
      case (state_q)
         MONITOR: begin
            if (win_code != FC_NONE) begin
               state_d = FAULT;
               fault_d = 1'b1;
               flash_d = 1'b1;
               code_d  = win_code;
               src_d   = win_src;
               count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            end
         end
         FAULT: begin
            // The first fault is held; only an acknowledge moves on.
            if (ack) begin
               state_d = REARM;
               fault_d = 1'b0;
               code_d  = FC_NONE;
               src_d   = 2'b00;
            end
         end
         REARM: begin
            // Exit once the heads have shown all-red long enough; the next
            // sample is treated as the first so no stale transition is judged.
            if (allred_d >= RED_CLEAR_C) begin
               state_d      = MONITOR;
               flash_d      = 1'b0;
               prev_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = MONITOR;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q      <= MONITOR;
         prev_valid_q <= 1'b0;
         allred_q     <= '0;
         fault_q      <= 1'b0;
         code_q       <= FC_NONE;
         src_q        <= 2'b00;
         flash_q      <= 1'b0;
         count_q      <= 8'd0;
      end else begin
         state_q      <= state_d;
         prev_valid_q <= prev_valid_d;
         allred_q     <= allred_d;
         fault_q      <= fault_d;
         code_q       <= code_d;
         src_q        <= src_d;
         flash_q      <= flash_d;
         count_q      <= count_d;
      end
   end

   assign fault       = fault_q;
   assign fault_code  = code_q;
   assign fault_src   = src_q;
   assign flash       = flash_q;
   assign fault_count = count_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor: a table of per-edge vectors
// with hand-computed outputs, followed by a fault_count saturation loop.
module tb_signal_conflict_monitor;

   localparam logic [1:0] R = 2'b00;
   localparam logic [1:0] Y = 2'b01;
   localparam logic [1:0] G = 2'b10;
   localparam logic [1:0] X = 2'b11;

   logic       clock;
   logic       clear_n;
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic       ack;
   logic       fault;
   logic [2:0] fault_code;
   logic [1:0] fault_src;
   logic       flash;
   logic [7:0] fault_count;

   int errors = 0;
   int checks = 0;

   signal_conflict_monitor dut (
      .clock       (clock),
      .clear_n     (clear_n),
      .hwy         (hwy),
      .cntry       (cntry),
      .ack         (ack),
      .fault       (fault),
      .fault_code  (fault_code),
      .fault_src   (fault_src),
      .flash       (flash),
      .fault_count (fault_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] hwy;
      logic [1:0] cntry;
      logic       ack;
      logic       rst_n;
      logic       fault;
      logic [2:0] code;
      logic [1:0] src;
      logic       flash;
      logic [7:0] count;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drive one edge's inputs, clock it, and settle past the edge.
   task automatic apply(input logic [1:0] h, input logic [1:0] c, input logic a, input logic rn);
      hwy     = h;
      cntry   = c;
      ack     = a;
      clear_n = rn;
      @(posedge clock);
      #1;
   endtask

   function automatic vec_t mk(input logic [1:0] h, input logic [1:0] c, input logic a,
                               input logic rn, input logic f, input logic [2:0] code,
                               input logic [1:0] src, input logic fl, input logic [7:0] cnt);
      vec_t v;
      v.hwy = h; v.cntry = c; v.ack = a; v.rst_n = rn;
      v.fault = f; v.code = code; v.src = src; v.flash = fl; v.count = cnt;
      return v;
   endfunction

   initial begin
      logic [7:0] exp_cnt;
      hwy = R; cntry = R; ack = 1'b0; clear_n = 1'b0;

      //                 hwy cntry ack rst  flt code src fl cnt
      // Reset, then a fully legal cycle.
      vecs.push_back(mk(R, R, 0, 0,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(G, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(G, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(G, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(G, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(G, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(R, G, 0, 1,   0, 0, 2'b00, 0, 0));
      // Reset, then GREEN->RED directly: SKIP_YELLOW from highway.
      vecs.push_back(mk(R, R, 0, 0,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(G, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(R, R, 0, 1,   1, 3, 2'b01, 1, 1));
      // Reset while in FAULT clears everything; legal sequence follows.
      vecs.push_back(mk(R, R, 0, 0,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(G, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(G, R, 0, 1,   0, 0, 2'b00, 0, 0));
      // Two yellows only: SHORT_YELLOW; later conflict ignored in FAULT.
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(R, R, 0, 1,   1, 5, 2'b01, 1, 1));
      vecs.push_back(mk(G, G, 0, 1,   1, 5, 2'b01, 1, 1));
      // Acknowledge, all-red re-arm, then immediate RED->GREEN not judged.
      vecs.push_back(mk(G, R, 1, 1,   0, 0, 2'b00, 1, 1));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 1, 1));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 1));
      vecs.push_back(mk(G, R, 0, 1,   0, 0, 2'b00, 0, 1));
      // Same edge SKIP_YELLOW (hwy) and NO_CLEARANCE (cntry): code 3 wins.
      vecs.push_back(mk(R, G, 0, 1,   1, 3, 2'b01, 1, 2));
      vecs.push_back(mk(R, R, 1, 1,   0, 0, 2'b00, 1, 2));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 2));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 2));
      // Both GREEN: CONFLICT from both approaches.
      vecs.push_back(mk(G, G, 0, 1,   1, 2, 2'b11, 1, 3));
      vecs.push_back(mk(R, R, 1, 1,   0, 0, 2'b00, 1, 3));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 3));
      // Illegal code on the first sample after re-arm is still caught.
      vecs.push_back(mk(X, R, 0, 1,   1, 1, 2'b01, 1, 4));
      vecs.push_back(mk(R, R, 1, 1,   0, 0, 2'b00, 1, 4));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 4));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 4));
      // Country RED->YELLOW: BAD_SEQ from country.
      vecs.push_back(mk(R, Y, 0, 1,   1, 4, 2'b10, 1, 5));
      vecs.push_back(mk(R, R, 1, 1,   0, 0, 2'b00, 1, 5));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 5));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 5));
      // ack in MONITOR is ignored; then only one all-red edge before GREEN.
      vecs.push_back(mk(G, R, 1, 1,   0, 0, 2'b00, 0, 5));
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 5));
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 5));
      vecs.push_back(mk(Y, R, 0, 1,   0, 0, 2'b00, 0, 5));
      vecs.push_back(mk(R, R, 0, 1,   0, 0, 2'b00, 0, 5));
      vecs.push_back(mk(R, G, 0, 1,   1, 6, 2'b10, 1, 6));

      @(negedge clock);
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].hwy, vecs[i].cntry, vecs[i].ack, vecs[i].rst_n);
         check($sformatf("vec%0d {fault,code,src,flash,count}", i),
               {17'd0, fault, fault_code, fault_src, flash, fault_count},
               {17'd0, vecs[i].fault, vecs[i].code, vecs[i].src, vecs[i].flash, vecs[i].count});
      end

      // fault_count saturation: repeat ack / re-arm / illegal-code fault.
      exp_cnt = 8'd6;
      for (int i = 0; i < 252; i++) begin
         apply(R, R, 1'b1, 1'b1);
         apply(R, R, 1'b0, 1'b1);
         apply(X, R, 1'b0, 1'b1);
         exp_cnt = (exp_cnt == 8'hFF) ? exp_cnt : exp_cnt + 8'd1;
         check($sformatf("sat%0d {fault,code,count}", i),
               {20'd0, fault, fault_code, fault_count}, {20'd0, 1'b1, 3'd1, exp_cnt});
      end

      // Reset after saturation returns every output to zero.
      apply(R, R, 1'b0, 1'b0);
      check("final_reset {fault,code,src,flash,count}",
            {17'd0, fault, fault_code, fault_src, flash, fault_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/signal_conflict_monitor.md
# signal_conflict_monitor

Independent safety monitor on the signal-head side of the intersection: samples the highway and country-road light codes driven by the controller and checks that they never conflict or step out of sequence. On the first violation it latches a coded fault and asserts `flash`, which forces both heads to flashing red. The fault is cleared by an operator `ack` followed by an all-red re-arm period. Light encoding is shared with the controller: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN, 2'b11 illegal.

## Interface
- `MIN_YELLOW`, 3: minimum consecutive YELLOW samples before RED.
- `MIN_RED_CLEAR`, 2: minimum consecutive all-red samples before either approach turns GREEN.
- `CNT_W`, 4: dwell counter width; counters saturate at 2^CNT_W-1.
- `clock` in 1: single clock, rising edge.
- `clear_n` in 1: reset, synchronous, active-low.
- `hwy` in 2: highway light code under observation.
- `cntry` in 2: country-road light code under observation.
- `ack` in 1: operator fault acknowledge, level, sampled each edge.
- `fault` out 1: violation latched.
- `fault_code` out 3: 0 none, 1 ILLEGAL_CODE, 2 CONFLICT, 3 SKIP_YELLOW, 4 BAD_SEQ, 5 SHORT_YELLOW, 6 NO_CLEARANCE.
- `fault_src` out 2: bit0 highway, bit1 country; the approach(es) causing the latched code.
- `flash` out 1: force both heads to flashing red.
- `fault_count` out 8: number of faults latched since reset, saturates at 255.

## Operation
- States: MONITOR, FAULT, REARM. Reset state is MONITOR.
- Reset values: all outputs 0; `prev_valid` 0; all counters 0.
- Per approach, tracked state is: previous color; dwell count (consecutive edges at which the same color was sampled, set to 1 on a change, saturating).
- `allred_cnt` is the number of consecutive edges at which both approaches were sampled RED, saturating.
- Checks run in MONITOR at every edge. Transition checks are skipped while `prev_valid`=0, which covers the first sample after reset or after REARM.
  - Either input equals 11: ILLEGAL_CODE.
  - Both inputs are non-RED: CONFLICT.
  - GREEN→RED: SKIP_YELLOW.
  - YELLOW→GREEN or RED→YELLOW: BAD_SEQ.
  - YELLOW→RED with prior yellow dwell < `MIN_YELLOW`: SHORT_YELLOW.
  - RED→GREEN with prior `allred_cnt` < `MIN_RED_CLEAR`: NO_CLEARANCE.
- Several violations at one edge: the lowest code number wins. `fault_src` is the OR of the approaches that raised the winning code.
- MONITOR→FAULT on any violation:
  - `fault`=1, `flash`=1.
  - `fault_code`/`fault_src` loaded.
  - `fault_count` incremented.
- In FAULT:
  - Further violations are ignored; the first fault is held.
  - `ack`=1 moves to REARM and clears `fault`, `fault_code` and `fault_src`.
  - `flash` stays 1.
- In REARM:
  - No checks run; `flash`=1.
  - When `allred_cnt` reaches `MIN_RED_CLEAR`, go to MONITOR with `flash`=0 and `prev_valid`=0.
- `ack` in MONITOR or REARM is ignored.
- Trackers update at every edge in every state, so dwell and all-red counts stay current.

## Timing
- Inputs are sampled at rising edge N. A violation at N is visible on `fault`/`flash` after edge N, i.e. one cycle of latency.
- `ack` sampled at edge N: `fault`=0 after edge N; `flash` is still held.
- REARM exit: `flash` drops after the edge at which `allred_cnt` reaches `MIN_RED_CLEAR`.
- Reset: `clear_n`=0 at any edge, in any state, returns everything to reset values after that edge.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Package `signal_mon_pkg` holds:
  - Color constants RED/YELLOW/GREEN/ILLEGAL.
  - Fault code constants 0–6.
  - The state enum MONITOR/FAULT/REARM.
- Sub-module `approach_tracker`, instantiated twice:
  - Holds the previous color and dwell counter.
  - Outputs per-approach flags: is_red, illegal, skip_yellow, bad_seq, short_yellow, red_to_green.
- Top level holds `allred_cnt`, the CONFLICT and NO_CLEARANCE checks, the priority encoder, the FSM and `fault_count`.

## Test plan
- Legal cycle, default parameters. Sequence: hwy GREEN ×5, YELLOW ×3, RED; cntry RED for 2 all-red edges; then cntry GREEN. Required: `fault`=0 throughout, `fault_count`=0.
- hwy GREEN→RED directly, cntry RED. Required one cycle later: `fault`=1, `fault_code`=3, `fault_src`=01, `flash`=1, `fault_count`=1.
- hwy YELLOW for 2 edges then RED. Required: `fault_code`=5, `fault_src`=01. A following conflict while in FAULT leaves the code at 5.
- Same edge: hwy GREEN→RED while cntry RED→GREEN with `allred_cnt`=0. Required: `fault_code`=3, `fault_src`=01 (SKIP_YELLOW outranks NO_CLEARANCE). Separately, hwy=10 with cntry=10 gives code 2, `fault_src`=11.
- FAULT, then `ack`=1 for one cycle. Required: `fault`=0 and `flash`=1 next cycle. Hold hwy=cntry=RED for 2 edges: `flash`=0 and back in MONITOR. Then hwy RED→GREEN immediately is not flagged.
- `clear_n`=0 for one edge while in FAULT with `fault_count`=1. Required: all outputs 0 next cycle. A subsequent legal sequence raises no fault.
